output_io_ser: RTL and testbench
================================

# output_io_ser

Parametrised output I/O serializer bank. It is the next generation of the registered output path behind the output pads. It accepts one parallel word per channel over a valid/ready handshake and shifts each word onto its channel's pad-side data line, one bit per clock, with a registered output enable per channel. It sits between fabric logic and the pad cells and replaces a single-bit buffered or registered output with an N-channel, ratio-R gearbox.

## Interface
- `NCH`, default 4: number of output channels (1..16).
- `SER_RATIO`, default 4: bits per word per channel (2..8).
- `IDLE_LEVEL`, default 1'b0: value driven on every `F2A` bit when no word is in flight.

- `IQC` input 1: clock. All state changes on its rising edge.
- `QRT` input 1: reset, asynchronous, active-high.
- `OQI` input NCH*SER_RATIO: parallel data. Channel c's word is `OQI[c*SER_RATIO +: SER_RATIO]`.
- `OQI_VALID` input 1: the `OQI`/`OE` word is valid.
- `OQI_READY` output 1: the block accepts the word in this cycle.
- `OE` input NCH: per-channel output enable, sampled together with the word.
- `F2A` output NCH: serial pad data, registered.
- `F2A_OE` output NCH: pad output enable, registered.
- `BUSY` output 1: a word is in flight (the state is SHIFT).

## Operation
- A word is accepted on the edge where `OQI_VALID && OQI_READY` holds.
- The FSM has two states, IDLE and SHIFT. It also has a beat counter `beat`, which is clog2(SER_RATIO) bits wide and runs 0..SER_RATIO-1.
- IDLE: `OQI_READY`=1. On accept the FSM goes to SHIFT with `beat`=0. Each lane loads its shift register, bit 0 goes to `F2A`, and `OE` goes to `F2A_OE`.
- SHIFT: every edge advances `beat` and shifts every lane by one bit. The next bit is registered onto `F2A`.
- `OQI_READY`=1 only when `beat`==SER_RATIO-1 (the last beat).
- Accept on the last beat: the next word loads immediately and `beat` returns to 0, with no gap.
- Last beat with no accept: the FSM returns to IDLE. `F2A` = {NCH{IDLE_LEVEL}} and `F2A_OE` = 0.
- Bit order is LSB first unless configured otherwise.
- `OE` is latched once per word. Changes to `OE` mid-word are ignored.
- `F2A` shifts regardless of `OE`. `OE` only gates `F2A_OE`.
- `OQI_VALID` may drop while `OQI_READY` is 0. No data is lost, because no accept occurs.

## Timing
- Reset values: `F2A` = {NCH{IDLE_LEVEL}}, `F2A_OE` = 0, `BUSY` = 0, state IDLE, `beat` = 0.
- `OQI_READY` is forced to 0 while `QRT` is high. It is combinational from the state and `QRT` only, never from `OQI_VALID`.
- Latency: for a word accepted at edge k, bit i appears on `F2A` after edge k+i, for i = 0..SER_RATIO-1.
- The word occupies exactly SER_RATIO cycles. Back-to-back throughput is one word per SER_RATIO cycles.
- Reset mid-word: asserting `QRT` clears everything asynchronously and the partial word is discarded. After release, the next accepted word starts at beat 0.
- Reset held across an edge with `OQI_VALID` high: no accept.

## Configuration
- `OUTPUT_IO_SER_MSB_FIRST_EN`
  - Defined: each lane shifts MSB first, so bit SER_RATIO-1 is driven after edge k.
  - Undefined: LSB first.
  - Latency and handshake are identical in both builds.

## Structure
- Shared package `output_io_pkg` holds:
  - the state enum (IDLE, SHIFT);
  - the `beat` width function;
  - the parameter range checks.
- Sub-module `out_ser_lane`: one channel's shift register plus its `F2A`/`F2A_OE` registers. It takes `load`, `shift`, `idle`, a word and an oe bit.
- The top level holds the FSM and counter, and instantiates NCH lanes in a generate loop.

## Test plan
All scenarios use NCH=2, SER_RATIO=4, IDLE_LEVEL=0.
- Reset: assert `QRT` asynchronously between edges → `F2A`=2'b00, `F2A_OE`=2'b00, `BUSY`=0 and `OQI_READY`=0 immediately. After release, `OQI_READY`=1.
- Single word: `OQI`=8'hA5, `OE`=2'b11, accepted at edge k → after edges k..k+3, `F2A[0]` = 1,0,1,0 and `F2A[1]` = 0,1,0,1, with `F2A_OE`=2'b11. After edge k+4, `F2A`=00, `F2A_OE`=00, `BUSY`=0.
- Back-to-back: 8'hA5 then 8'h3C with `OQI_VALID` held → `OQI_READY` pulses only on the last beat. `F2A[0]` = 1,0,1,0,0,0,1,1 across 8 consecutive cycles, with no idle gap.
- Reset mid-word: assert `QRT` after beat 1 of 8'hFF → outputs go to 0 at once. A later 8'h0F starts at beat 0 and gives `F2A[0]` = 1,1,1,1.
- OE gating: `OE`=2'b01, and `OE` toggles to 2'b10 mid-word → `F2A_OE` stays 2'b01 for the whole word, while `F2A[1]` still shifts its data.
- Bit order: with `OUTPUT_IO_SER_MSB_FIRST_EN` defined, 8'hA5 → `F2A[0]` = 0,1,0,1.

Source files
------------

// File: rtl/output_io_pkg.sv
// Shared definitions for the output_io_ser serializer bank: FSM state encoding,
// beat counter width and parameter range checks.
package output_io_pkg;

  // FSM state encoding
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  localparam int NCH_MIN   = 1;
  localparam int NCH_MAX   = 16;
  localparam int RATIO_MIN = 2;
  localparam int RATIO_MAX = 8;

  // Width of the beat counter that runs 0..ratio-1.
  function automatic int beat_width(input int ratio);
    return (ratio > 2) ? $clog2(ratio) : 1;
  endfunction

  function automatic bit nch_ok(input int nch);
    return (nch >= NCH_MIN) && (nch <= NCH_MAX);
  endfunction

  function automatic bit ratio_ok(input int ratio);
    return (ratio >= RATIO_MIN) && (ratio <= RATIO_MAX);
  endfunction

endpackage

// File: rtl/out_ser_lane.sv
// One serializer channel: shift register plus registered pad data and enable.
// Bit order follows OUTPUT_IO_SER_MSB_FIRST_EN (defined: MSB first, else LSB first).
module out_ser_lane #(
  parameter int   SER_RATIO  = 4,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 shift,
  input  logic                 idle,
  input  logic [SER_RATIO-1:0] word,
  input  logic                 oe,
  output logic                 f2a,
  output logic                 f2a_oe
);

  logic [SER_RATIO-1:0] sreg;
  logic                 load_bit;
  logic [SER_RATIO-1:0] load_rest;
  logic                 head_bit;
  logic [SER_RATIO-1:0] sreg_next;

  // The bit leaving first is stripped at load, so the register head is always the next bit.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    load_bit  = 1'b0;
    load_rest = '0;
    head_bit  = 1'b0;
    sreg_next = '0;
`ifdef OUTPUT_IO_SER_MSB_FIRST_EN
    load_bit  = word[SER_RATIO-1];
    load_rest = {word[SER_RATIO-2:0], 1'b0};
    head_bit  = sreg[SER_RATIO-1];
    sreg_next = {sreg[SER_RATIO-2:0], 1'b0};
`else
    load_bit  = word[0];
    load_rest = {1'b0, word[SER_RATIO-1:1]};
    head_bit  = sreg[0];
    sreg_next = {1'b0, sreg[SER_RATIO-1:1]};
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so all lanes update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the shift register is tiny, so it is reset along with the pad registers.
      sreg   <= '0;
      f2a    <= IDLE_LEVEL;
      f2a_oe <= 1'b0;
    end else if (load) begin
      sreg   <= load_rest;
      f2a    <= load_bit;
      f2a_oe <= oe;
    end else if (shift) begin
      sreg   <= sreg_next;
      f2a    <= head_bit;
    end else if (idle) begin
      f2a    <= IDLE_LEVEL;
      f2a_oe <= 1'b0;
    end
  end

endmodule

// File: rtl/output_io_ser.sv
// N-channel, ratio-R output serializer bank: valid/ready word intake, IDLE/SHIFT FSM
// with beat counter, one out_ser_lane per channel. Option: OUTPUT_IO_SER_MSB_FIRST_EN.
module output_io_ser
  import output_io_pkg::*;
#(
  parameter int   NCH        = 4,
  parameter int   SER_RATIO  = 4,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic                     IQC,
  input  logic                     QRT,
  input  logic [NCH*SER_RATIO-1:0] OQI,
  input  logic                     OQI_VALID,
  output logic                     OQI_READY,
  input  logic [NCH-1:0]           OE,
  output logic [NCH-1:0]           F2A,
  output logic [NCH-1:0]           F2A_OE,
  output logic                     BUSY
);

  localparam int BW = beat_width(SER_RATIO);
  localparam logic [BW-1:0] LAST_BEAT = BW'(SER_RATIO - 1);

  if (!nch_ok(NCH)) begin : g_bad_nch
    $error("output_io_ser: NCH out of range 1..16");
  end
  if (!ratio_ok(SER_RATIO)) begin : g_bad_ratio
    $error("output_io_ser: SER_RATIO out of range 2..8");
  end

  logic [0:0]    state;
  logic [BW-1:0] beat;
  logic          last;
  logic          accept;
  logic          lane_load;
  logic          lane_shift;
  logic          lane_idle;

  // Ready depends only on state and reset, never on OQI_VALID.
  assign last      = (state == ST_SHIFT) && (beat == LAST_BEAT);
  assign OQI_READY = !QRT && ((state == ST_IDLE) || last);
  assign accept    = OQI_VALID && OQI_READY;
  assign BUSY      = (state == ST_SHIFT);

  assign lane_load  = accept;
  assign lane_shift = (state == ST_SHIFT) && !last;
  assign lane_idle  = last && !accept;

  always_ff @(posedge IQC or posedge QRT) begin
    if (QRT) begin
      state <= ST_IDLE;
      beat  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state <= ST_SHIFT;
            beat  <= '0;
          end
        end
        default: begin
          if (!last) begin
            beat <= beat + BW'(1);
          end else if (accept) begin
            beat <= '0;
          end else begin
            state <= ST_IDLE;
            beat  <= '0;
          end
        end
      endcase
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_lane
    out_ser_lane #(
      .SER_RATIO  (SER_RATIO),
      .IDLE_LEVEL (IDLE_LEVEL)
    ) u_lane (
      .clk    (IQC),
      .rst    (QRT),
      .load   (lane_load),
      .shift  (lane_shift),
      .idle   (lane_idle),
      .word   (OQI[c*SER_RATIO +: SER_RATIO]),
      .oe     (OE[c]),
      .f2a    (F2A[c]),
      .f2a_oe (F2A_OE[c])
    );
  end

endmodule

// File: tb/tb_output_io_ser.sv
// Directed self-checking bench for output_io_ser with NCH=2, SER_RATIO=4, IDLE_LEVEL=0.
// Expected pad values follow OUTPUT_IO_SER_MSB_FIRST_EN when it is defined.
module tb_output_io_ser;

  logic       IQC;
  logic       QRT;
  logic [7:0] OQI;
  logic       OQI_VALID;
  logic       OQI_READY;
  logic [1:0] OE;
  logic [1:0] F2A;
  logic [1:0] F2A_OE;
  logic       BUSY;

  int n_cmp  = 0;
  int n_fail = 0;

  output_io_ser #(
    .NCH        (2),
    .SER_RATIO  (4),
    .IDLE_LEVEL (1'b0)
  ) dut (
    .IQC       (IQC),
    .QRT       (QRT),
    .OQI       (OQI),
    .OQI_VALID (OQI_VALID),
    .OQI_READY (OQI_READY),
    .OE        (OE),
    .F2A       (F2A),
    .F2A_OE    (F2A_OE),
    .BUSY      (BUSY)
  );

  initial IQC = 1'b0;
  always #5 IQC = ~IQC;

  // Pad pair {lane1, lane0} expected on beat i of an 8-bit word.
  function automatic logic [1:0] pads(input logic [7:0] w, input int i);
    int idx;
`ifdef OUTPUT_IO_SER_MSB_FIRST_EN
    idx = 3 - i;
`else
    idx = i;
`endif
    return {w[4 + idx], w[idx]};
  endfunction

  task automatic tick();
    @(posedge IQC);
    #1;
  endtask

  task automatic chk(input string tag, input logic [1:0] f, input logic [1:0] oe,
                     input logic busy, input logic rdy);
    n_cmp++;
    assert (F2A === f) else begin
      n_fail++;
      $error("FAIL %s F2A: observed %b expected %b", tag, F2A, f);
    end
    n_cmp++;
    assert (F2A_OE === oe) else begin
      n_fail++;
      $error("FAIL %s F2A_OE: observed %b expected %b", tag, F2A_OE, oe);
    end
    n_cmp++;
    assert (BUSY === busy) else begin
      n_fail++;
      $error("FAIL %s BUSY: observed %b expected %b", tag, BUSY, busy);
    end
    n_cmp++;
    assert (OQI_READY === rdy) else begin
      n_fail++;
      $error("FAIL %s OQI_READY: observed %b expected %b", tag, OQI_READY, rdy);
    end
  endtask

  initial begin
    QRT       = 1'b1;
    OQI       = 8'h00;
    OQI_VALID = 1'b0;
    OE        = 2'b00;

    // Reset state, and a valid word presented during reset is not accepted.
    #2;
    chk("reset_hold", 2'b00, 2'b00, 1'b0, 1'b0);
    OQI       = 8'hFF;
    OE        = 2'b11;
    OQI_VALID = 1'b1;
    tick();
    chk("reset_valid_no_accept", 2'b00, 2'b00, 1'b0, 1'b0);
    OQI_VALID = 1'b0;
    QRT       = 1'b0;
    #1;
    chk("reset_release", 2'b00, 2'b00, 1'b0, 1'b1);

    // Single word 8'hA5, hand values for the default LSB-first build: lane0 1,0,1,0; lane1 0,1,0,1.
    tick();
    OQI       = 8'hA5;
    OE        = 2'b11;
    OQI_VALID = 1'b1;
    tick();
    OQI_VALID = 1'b0;
    OQI       = 8'h00;
`ifdef OUTPUT_IO_SER_MSB_FIRST_EN
    chk("single_b0", 2'b10, 2'b11, 1'b1, 1'b0);
`else
    chk("single_b0", 2'b01, 2'b11, 1'b1, 1'b0);
`endif
    tick();
    chk("single_b1", pads(8'hA5, 1), 2'b11, 1'b1, 1'b0);
    tick();
    chk("single_b2", pads(8'hA5, 2), 2'b11, 1'b1, 1'b0);
    tick();
    chk("single_b3", pads(8'hA5, 3), 2'b11, 1'b1, 1'b1);
    tick();
    chk("single_idle", 2'b00, 2'b00, 1'b0, 1'b1);

    // Back-to-back 8'hA5 then 8'h3C with OQI_VALID held; next word staged while not ready.
    OQI       = 8'hA5;
    OE        = 2'b11;
    OQI_VALID = 1'b1;
    tick();
    OQI = 8'h3C;
    chk("b2b_a_b0", pads(8'hA5, 0), 2'b11, 1'b1, 1'b0);
    for (int i = 1; i < 4; i++) begin
      tick();
      chk($sformatf("b2b_a_b%0d", i), pads(8'hA5, i), 2'b11, 1'b1, (i == 3));
    end
    tick();
    OQI_VALID = 1'b0;
    chk("b2b_c_b0", pads(8'h3C, 0), 2'b11, 1'b1, 1'b0);
    for (int i = 1; i < 4; i++) begin
      tick();
      chk($sformatf("b2b_c_b%0d", i), pads(8'h3C, i), 2'b11, 1'b1, (i == 3));
    end
    tick();
    chk("b2b_idle", 2'b00, 2'b00, 1'b0, 1'b1);

    // Reset mid-word: 8'hFF interrupted after beat 1, QRT held across an edge with valid high.
    OQI       = 8'hFF;
    OE        = 2'b11;
    OQI_VALID = 1'b1;
    tick();
    OQI_VALID = 1'b0;
    chk("midrst_b0", 2'b11, 2'b11, 1'b1, 1'b0);
    tick();
    chk("midrst_b1", 2'b11, 2'b11, 1'b1, 1'b0);
    #2;
    QRT = 1'b1;
    #1;
    chk("midrst_async", 2'b00, 2'b00, 1'b0, 1'b0);
    OQI       = 8'h0F;
    OQI_VALID = 1'b1;
    tick();
    chk("midrst_held", 2'b00, 2'b00, 1'b0, 1'b0);
    #2;
    QRT = 1'b0;
    #1;
    chk("midrst_release", 2'b00, 2'b00, 1'b0, 1'b1);
    tick();
    OQI_VALID = 1'b0;
    chk("after_rst_b0", pads(8'h0F, 0), 2'b11, 1'b1, 1'b0);
    for (int i = 1; i < 4; i++) begin
      tick();
      chk($sformatf("after_rst_b%0d", i), pads(8'h0F, i), 2'b11, 1'b1, (i == 3));
    end
    tick();
    chk("after_rst_idle", 2'b00, 2'b00, 1'b0, 1'b1);

    // OE gating: OE latched at accept, mid-word change ignored, lane1 data still shifts.
    OQI       = 8'h96;
    OE        = 2'b01;
    OQI_VALID = 1'b1;
    tick();
    OQI_VALID = 1'b0;
    OE        = 2'b10;
    chk("oe_b0", pads(8'h96, 0), 2'b01, 1'b1, 1'b0);
    for (int i = 1; i < 4; i++) begin
      tick();
      chk($sformatf("oe_b%0d", i), pads(8'h96, i), 2'b01, 1'b1, (i == 3));
    end
    tick();
    chk("oe_idle", 2'b00, 2'b00, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
